// File: rtl/ahb_burst_sequencer.sv
// rtl/ahb_burst_sequencer.sv - expands one burst request into per-beat AHB master stimulus
// Generates NONSEQ/SEQ/BUSY sequencing, INCR/WRAP addressing and read-data capture for top_ahb.
module ahb_burst_sequencer #(
    parameter int BEAT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        hreset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_burst,
    input  logic [2:0]  req_size,
    input  logic [4:0]  req_len,
    input  logic        req_write,
    input  logic [1:0]  req_sel,
    input  logic [31:0] wdata,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    input  logic [31:0] hrdata_in,
    output logic [31:0] in_haddr,
    output logic [31:0] in_hwdata,
    output logic [1:0]  in_htrans,
    output logic [1:0]  in_hsel,
    output logic [2:0]  in_hburst,
    output logic [2:0]  in_hsize,
    output logic        in_hwrite,
    output logic        enable,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        done,
    output logic        req_err
);
    localparam int CW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(BEAT_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_BEAT  = 3'd2;
    localparam logic [2:0] S_STALL = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_BUSY   = 2'b01;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    logic [2:0]    r_state;
    logic [31:0]   r_addr;
    logic [31:0]   r_hwdata;
    logic [2:0]    r_burst;
    logic [2:0]    r_size;
    logic          r_write;
    logic [1:0]    r_sel;
    logic [4:0]    r_nbeats;
    logic [4:0]    r_beat;
    logic [CW-1:0] r_cyc;
    logic          r_first;
    logic [31:0]   r_rdata;
    logic          r_rdata_valid;
    logic          r_req_err;

    logic        w_accept;
    logic        w_legal;
    logic [4:0]  w_len;
    logic        w_beat_end;
    logic        w_last_beat;
    logic        w_wrap;
    logic [31:0] w_step;
    logic [31:0] w_mask;
    logic [31:0] w_inc;
    logic [31:0] w_next;

    assign req_ready = (r_state == S_IDLE) || (r_state == S_FIN);
    assign w_accept  = req_valid && req_ready;
    assign w_legal   = (req_size <= 3'd2);

    always_comb begin
        w_len = 5'd16;
        case (req_burst)
            3'b000: w_len = 5'd1;
            3'b001: begin
                if (req_len == 5'd0)
                    w_len = 5'd1;
                else if (req_len > 5'd16)
                    w_len = 5'd16;
                else
                    w_len = req_len;
            end
            3'b010, 3'b011: w_len = 5'd4;
            3'b100, 3'b101: w_len = 5'd8;
            default:        w_len = 5'd16;
        endcase
    end

    assign w_beat_end  = (r_cyc == CYC_LAST);
    assign w_last_beat = (r_beat == (r_nbeats - 5'd1));
    assign w_wrap      = (r_burst == 3'b010) || (r_burst == 3'b100) || (r_burst == 3'b110);
    assign w_step      = 32'd1 << r_size;
    // Wrap boundary is beats*(1<<size); the mask selects the offset inside it.
    assign w_mask      = ({27'd0, r_nbeats} << r_size) - 32'd1;
    assign w_inc       = r_addr + w_step;
    assign w_next      = w_wrap ? ((r_addr & ~w_mask) | (w_inc & w_mask)) : w_inc;

    // Data for beat k+1 is taken in the last cycle of beat k, or while waiting/stalled.
    assign wdata_ready = wdata_valid &&
                         ((r_state == S_WAIT) || (r_state == S_STALL) ||
                          ((r_state == S_BEAT) && r_write && w_beat_end && !w_last_beat));

    always_ff @(posedge clk or posedge hreset) begin
        if (hreset) begin
            r_state       <= S_IDLE;
            r_addr        <= 32'd0;
            r_hwdata      <= 32'd0;
            r_burst       <= 3'd0;
            r_size        <= 3'd0;
            r_write       <= 1'b0;
            r_sel         <= 2'd0;
            r_nbeats      <= 5'd1;
            r_beat        <= 5'd0;
            r_cyc         <= '0;
            r_first       <= 1'b0;
            r_rdata       <= 32'd0;
            r_rdata_valid <= 1'b0;
            r_req_err     <= 1'b0;
        end else begin
            r_rdata_valid <= 1'b0;
            r_req_err     <= 1'b0;
            if (wdata_ready)
                r_hwdata <= wdata;
            case (r_state)
                S_IDLE, S_FIN: begin
                    r_state <= S_IDLE;
                    if (w_accept) begin
                        if (!w_legal) begin
                            r_req_err <= 1'b1;
                        end else begin
                            r_addr   <= req_addr & ~((32'd1 << req_size) - 32'd1);
                            r_burst  <= req_burst;
                            r_size   <= req_size;
                            r_write  <= req_write;
                            r_sel    <= req_sel;
                            r_nbeats <= w_len;
                            r_beat   <= 5'd0;
                            r_cyc    <= '0;
                            r_first  <= 1'b1;
                            r_state  <= req_write ? S_WAIT : S_BEAT;
                        end
                    end
                end
                S_WAIT: begin
                    if (wdata_valid)
                        r_state <= S_BEAT;
                end
                S_BEAT: begin
                    if (!r_write && w_beat_end) begin
                        r_rdata       <= hrdata_in;
                        r_rdata_valid <= 1'b1;
                    end
                    if (w_beat_end) begin
                        r_cyc <= '0;
                        if (w_last_beat) begin
                            r_state <= S_FIN;
                        end else begin
                            r_addr  <= w_next;
                            r_beat  <= r_beat + 5'd1;
                            r_first <= 1'b0;
                            if (r_write && !wdata_valid)
                                r_state <= S_STALL;
                        end
                    end else begin
                        r_cyc <= r_cyc + CW'(1);
                    end
                end
                S_STALL: begin
                    if (wdata_valid)
                        r_state <= S_BEAT;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_htrans = HT_IDLE;
        case (r_state)
            S_BEAT:  in_htrans = r_first ? HT_NONSEQ : HT_SEQ;
            S_STALL: in_htrans = HT_BUSY;
            default: in_htrans = HT_IDLE;
        endcase
    end

    assign enable      = (r_state == S_BEAT) || (r_state == S_STALL);
    assign done        = (r_state == S_FIN);
    assign in_haddr    = r_addr;
    assign in_hwdata   = r_hwdata;
    assign in_hsel     = r_sel;
    assign in_hburst   = r_burst;
    assign in_hsize    = r_size;
    assign in_hwrite   = r_write;
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign req_err     = r_req_err;
endmodule
